// File: rtl/router_sync_pkg.sv
// Shared router definitions: destination address encodings, timeout defaults
// and the address-to-write-strobe decode reused by the input FSM and the sync block.
package router_sync_pkg;

   localparam logic [1:0] ADDR_0    = 2'b00;
   localparam logic [1:0] ADDR_1    = 2'b01;
   localparam logic [1:0] ADDR_2    = 2'b10;
   localparam logic [1:0] ADDR_NONE = 2'b11;

   localparam int TIMEOUT_DEF = 30;
   localparam int CNT_W_DEF   = 5;

   // ADDR_NONE decodes to no strobe, so writes to it vanish.
   function automatic logic [2:0] addr_onehot(input logic [1:0] addr);
      logic [2:0] oh;
      case (addr)
         ADDR_0:  oh = 3'b001;
         ADDR_1:  oh = 3'b010;
         ADDR_2:  oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel read timeout: counts cycles a FIFO holds data its destination
// is not reading and emits a one-cycle registered soft_reset after TIMEOUT of them.
module router_sync_timer #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic clk,
   input  logic resetn,
   input  logic vld,
   input  logic read_enb,
   output logic soft_reset
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             soft_reset_q, soft_reset_d;

   // The soft_reset cycle itself does not count, so a FIFO left non-empty and
   // unread re-fires every TIMEOUT+1 cycles.
   always_comb begin
      cnt_d        = cnt_q;
      soft_reset_d = 1'b0;
      if (!vld || read_enb || soft_reset_q) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         soft_reset_d = 1'b1;
         cnt_d        = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q        <= '0;
         soft_reset_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         soft_reset_q <= soft_reset_d;
      end
   end

   assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync.sv
// Router synchroniser: latches the header address, steers write strobes and the
// full flag to the addressed FIFO, and runs a read timeout on each output channel.
module router_sync
   import router_sync_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       detect_add,
   input  logic [1:0] data_in,
   input  logic       write_enb_reg,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   output logic [2:0] write_enb,
   output logic       fifo_full,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2
);

   logic [1:0] addr_q, addr_d;

   always_comb begin
      addr_d = addr_q;
      if (detect_add) addr_d = data_in;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) addr_q <= ADDR_NONE;
      else         addr_q <= addr_d;
   end

   // Decode uses the registered address, so a header-cycle write sees the old one.
   always_comb begin
      write_enb = write_enb_reg ? addr_onehot(addr_q) : 3'b000;
      case (addr_q)
         ADDR_0:  fifo_full = full_0;
         ADDR_1:  fifo_full = full_1;
         ADDR_2:  fifo_full = full_2;
         default: fifo_full = 1'b0;
      endcase
   end

   assign vld_out_0 = ~empty_0;
   assign vld_out_1 = ~empty_1;
   assign vld_out_2 = ~empty_2;

   router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
      .clk        (clk),
      .resetn     (resetn),
      .vld        (vld_out_0),
      .read_enb   (read_enb_0),
      .soft_reset (soft_reset_0)
   );

   router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
      .clk        (clk),
      .resetn     (resetn),
      .vld        (vld_out_1),
      .read_enb   (read_enb_1),
      .soft_reset (soft_reset_1)
   );

   router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
      .clk        (clk),
      .resetn     (resetn),
      .vld        (vld_out_2),
      .read_enb   (read_enb_2),
      .soft_reset (soft_reset_2)
   );

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync: the driver pushes hand-computed output vectors
// {write_enb, fifo_full, vld_out[2:0], soft_reset[2:0]}; a negedge monitor pops and compares.
module tb_router_sync;

   logic       clk = 1'b0;
   logic       resetn;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic [2:0] rd;
   logic [2:0] emp;
   logic [2:0] ful;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   logic [9:0] exp_q[$];
   string      name_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .read_enb_0    (rd[0]),
      .read_enb_1    (rd[1]),
      .read_enb_2    (rd[2]),
      .empty_0       (emp[0]),
      .empty_1       (emp[1]),
      .empty_2       (emp[2]),
      .full_0        (ful[0]),
      .full_1        (ful[1]),
      .full_2        (ful[2]),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out_0     (vld_out_0),
      .vld_out_1     (vld_out_1),
      .vld_out_2     (vld_out_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] pack(input logic [2:0] we, input logic ff,
                                       input logic [2:0] vld, input logic [2:0] sr);
      return {we, ff, vld, sr};
   endfunction

   task automatic expect_out(input string nm, input logic [9:0] exp);
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [9:0] obs;
      logic [9:0] exp;
      string      nm;
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         obs = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
                soft_reset_2, soft_reset_1, soft_reset_0};
         vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got we=%b ff=%b vld=%b sr=%b, expected we=%b ff=%b vld=%b sr=%b",
                     nm, obs[9:7], obs[6], obs[5:3], obs[2:0],
                     exp[9:7], exp[6], exp[5:3], exp[2:0]);
         end
      end
   end

   typedef struct {
      logic [1:0] addr;
      logic [2:0] full;
      logic [2:0] we;
      logic       ff;
   } steer_t;

   steer_t steer_tab[5];

   initial begin
      steer_tab[0] = '{addr: 2'b10, full: 3'b100, we: 3'b100, ff: 1'b1};
      steer_tab[1] = '{addr: 2'b11, full: 3'b111, we: 3'b000, ff: 1'b0};
      steer_tab[2] = '{addr: 2'b00, full: 3'b001, we: 3'b001, ff: 1'b1};
      steer_tab[3] = '{addr: 2'b01, full: 3'b010, we: 3'b010, ff: 1'b1};
      steer_tab[4] = '{addr: 2'b00, full: 3'b110, we: 3'b001, ff: 1'b0};

      resetn = 1'b0; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
      rd = 3'b000; emp = 3'b111; ful = 3'b000;

      // reset state, FIFOs non-empty during reset
      tick();
      emp = 3'b000; write_enb_reg = 1'b1; ful = 3'b111;
      expect_out("reset_state", pack(3'b000, 1'b0, 3'b111, 3'b000));
      tick();
      resetn = 1'b1; emp = 3'b111; write_enb_reg = 1'b0; ful = 3'b000;
      expect_out("idle_after_reset", pack(3'b000, 1'b0, 3'b000, 3'b000));

      // address steering
      foreach (steer_tab[i]) begin
         tick();
         detect_add = 1'b1; data_in = steer_tab[i].addr; write_enb_reg = 1'b0;
         ful = steer_tab[i].full;
         for (int c = 0; c < 4; c++) begin
            tick();
            detect_add = 1'b0; write_enb_reg = 1'b1;
            expect_out($sformatf("steer_addr%0d", steer_tab[i].addr),
                       pack(steer_tab[i].we, steer_tab[i].ff, 3'b000, 3'b000));
         end
         tick();
         write_enb_reg = 1'b0;
         expect_out("steer_no_req", pack(3'b000, steer_tab[i].ff, 3'b000, 3'b000));
      end

      // header-cycle write decodes with the old address (00)
      tick();
      detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; ful = 3'b100;
      expect_out("header_old_addr", pack(3'b001, 1'b0, 3'b000, 3'b000));
      tick();
      detect_add = 1'b0;
      expect_out("header_new_addr", pack(3'b100, 1'b1, 3'b000, 3'b000));

      // asynchronous reset mid-cycle returns address to none
      tick();
      resetn = 1'b0;
      expect_out("async_reset_addr", pack(3'b000, 1'b0, 3'b000, 3'b000));
      tick();
      resetn = 1'b1; write_enb_reg = 1'b0; ful = 3'b000;
      expect_out("post_reset_idle", pack(3'b000, 1'b0, 3'b000, 3'b000));

      // timeout on channel 1
      tick();
      emp = 3'b101;
      for (int c = 0; c <= 32; c++) begin
         expect_out($sformatf("timeout1_c%0d", c),
                    pack(3'b000, 1'b0, 3'b010, (c == 30) ? 3'b010 : 3'b000));
         tick();
      end
      emp = 3'b111;
      expect_out("timeout1_drain", pack(3'b000, 1'b0, 3'b000, 3'b000));

      // timeout restart by a read at cycle 20
      tick();
      emp = 3'b101;
      for (int c = 0; c <= 52; c++) begin
         rd = (c == 20) ? 3'b010 : 3'b000;
         expect_out($sformatf("restart1_c%0d", c),
                    pack(3'b000, 1'b0, 3'b010, (c == 51) ? 3'b010 : 3'b000));
         tick();
      end
      rd = 3'b000; emp = 3'b111;
      expect_out("restart1_drain", pack(3'b000, 1'b0, 3'b000, 3'b000));

      // concurrent channels 0 and 2 with periodic re-fire
      tick();
      emp = 3'b010;
      for (int c = 0; c <= 63; c++) begin
         expect_out($sformatf("concurrent_c%0d", c),
                    pack(3'b000, 1'b0, 3'b101, (c == 30 || c == 61) ? 3'b101 : 3'b000));
         tick();
      end
      emp = 3'b111;
      expect_out("concurrent_drain", pack(3'b000, 1'b0, 3'b000, 3'b000));

      // mid-count reset on channel 0
      tick();
      emp = 3'b110;
      for (int c = 0; c < 15; c++) begin
         expect_out($sformatf("midcount_pre_c%0d", c), pack(3'b000, 1'b0, 3'b001, 3'b000));
         tick();
      end
      resetn = 1'b0;
      expect_out("midcount_reset", pack(3'b000, 1'b0, 3'b001, 3'b000));
      tick();
      resetn = 1'b1;
      for (int c = 0; c <= 31; c++) begin
         expect_out($sformatf("midcount_post_c%0d", c),
                    pack(3'b000, 1'b0, 3'b001, (c == 30) ? 3'b001 : 3'b000));
         tick();
      end
      emp = 3'b111;

      // final report
      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
